// File: rtl/id_pkg.sv
// Shared definitions for the identifier generator: FSM states, character
// classes, ASCII anchors and the letter/digit wrap helpers.
package id_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALPHA = 2'd1,
    DIGIT = 2'd2,
    TERM  = 2'd3
  } state_t;

  typedef enum logic {
    CLS_LETTER = 1'b0,
    CLS_DIGIT  = 1'b1
  } char_class_t;

  localparam logic [7:0] ASCII_ZERO    = 8'd48;
  localparam logic [7:0] ASCII_UPPER_A = 8'd65;
  localparam logic [7:0] ASCII_LOWER_A = 8'd97;
  localparam logic [4:0] LETTER_MOD    = 5'd26;
  localparam logic [3:0] DIGIT_MOD     = 4'd10;

  function automatic logic [4:0] clamp_base(input logic [4:0] base);
    return (base >= LETTER_MOD) ? 5'd0 : base;
  endfunction

  function automatic logic [4:0] next_letter(input logic [4:0] idx);
    return (idx == LETTER_MOD - 5'd1) ? 5'd0 : idx + 5'd1;
  endfunction

  function automatic logic [3:0] next_digit(input logic [3:0] idx);
    return (idx == DIGIT_MOD - 4'd1) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/id_char_sel.sv
// Combinational map from (class, index, case) to an ASCII byte; the
// terminator is handled by the caller since it is a parameter there.
module id_char_sel
  import id_pkg::*;
(
  input  char_class_t  cls,
  input  logic [4:0]   idx,
  input  logic         upper,
  output logic [7:0]   ascii
);

  always_comb begin
    ascii = 8'd0;
    if (cls == CLS_DIGIT) begin
      ascii = ASCII_ZERO + {4'd0, idx[3:0]};
    end else begin
      ascii = (upper ? ASCII_UPPER_A : ASCII_LOWER_A) + {3'd0, idx};
    end
  end

endmodule

// File: rtl/id_gen.sv
// Identifier generator: emits letters, then digits, then a terminator over a
// valid/ready byte stream. expect_flag carries the "ended in a digit" flag
// (named so because 'expect' is a reserved word).
module id_gen
  import id_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'd32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] alpha_len,
  input  logic [3:0] digit_len,
  input  logic [4:0] alpha_base,
  input  logic       upper,
  output logic [7:0] char,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       expect_flag,
  output logic       done
);

  state_t      state;
  logic [3:0]  rem;
  logic [3:0]  dlen_q;
  logic        upper_q;
  logic [4:0]  letter_idx;
  logic [3:0]  digit_idx;
  logic        handshake;

  char_class_t sel_cls;
  logic [4:0]  sel_idx;
  logic        sel_upper;
  logic [7:0]  sel_char;

  assign handshake = valid & ready;

  // Selects the character that becomes visible after the next handshake (or start).
  always_comb begin
    sel_cls   = CLS_LETTER;
    sel_idx   = clamp_base(alpha_base);
    sel_upper = upper;
    case (state)
      ALPHA: begin
        sel_upper = upper_q;
        if (rem == 4'd1) begin
          sel_cls = CLS_DIGIT;
          sel_idx = 5'd0;
        end else begin
          sel_idx = next_letter(letter_idx);
        end
      end
      DIGIT: begin
        sel_upper = upper_q;
        sel_cls   = CLS_DIGIT;
        sel_idx   = {1'b0, next_digit(digit_idx)};
      end
      default: ;
    endcase
  end

  id_char_sel u_char_sel (
    .cls   (sel_cls),
    .idx   (sel_idx),
    .upper (sel_upper),
    .ascii (sel_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= 4'd0;
      dlen_q      <= 4'd0;
      upper_q     <= 1'b0;
      letter_idx  <= 5'd0;
      digit_idx   <= 4'd0;
      char        <= 8'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      expect_flag <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dlen_q     <= digit_len;
            upper_q    <= upper;
            letter_idx <= clamp_base(alpha_base);
            rem        <= (alpha_len == 4'd0) ? 4'd1 : alpha_len;
            char       <= sel_char;
            valid      <= 1'b1;
            busy       <= 1'b1;
            state      <= ALPHA;
          end
        end
        ALPHA: begin
          if (handshake) begin
            if (rem == 4'd1) begin
              if (dlen_q != 4'd0) begin
                state     <= DIGIT;
                rem       <= dlen_q;
                digit_idx <= 4'd0;
                char      <= sel_char;
              end else begin
                state <= TERM;
                char  <= TERM_CHAR;
              end
            end else begin
              rem        <= rem - 4'd1;
              letter_idx <= next_letter(letter_idx);
              char       <= sel_char;
            end
          end
        end
        DIGIT: begin
          if (handshake) begin
            if (rem == 4'd1) begin
              state <= TERM;
              char  <= TERM_CHAR;
            end else begin
              rem       <= rem - 4'd1;
              digit_idx <= next_digit(digit_idx);
              char      <= sel_char;
            end
          end
        end
        TERM: begin
          if (handshake) begin
            state       <= IDLE;
            rem         <= 4'd0;
            char        <= 8'd0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            expect_flag <= (dlen_q != 4'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: each scenario drives one identifier and checks
// every offered byte plus the done/expect handshake against literal strings.
module tb_id_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] alpha_len;
  logic [3:0] digit_len;
  logic [4:0] alpha_base;
  logic       upper;
  logic [7:0] char;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       expect_flag;
  logic       done;

  int assert_count = 0;
  int fail_count   = 0;

  id_gen #(.TERM_CHAR(8'd32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alpha_len   (alpha_len),
    .digit_len   (digit_len),
    .alpha_base  (alpha_base),
    .upper       (upper),
    .char        (char),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .expect_flag (expect_flag),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] alen, input logic [3:0] dlen,
                               input logic [4:0] base, input logic up, input logic keep_start);
    alpha_len  = alen;
    digit_len  = dlen;
    alpha_base = base;
    upper      = up;
    start      = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
  endtask

  // Consumes the whole string with ready=1, then checks the completion cycle.
  task automatic expectSeq(input string tag, input string s, input logic exp_expect);
    ready = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      checkOutput({tag, "_valid"}, {7'd0, valid}, 8'd1);
      checkOutput({tag, "_char"}, char, s[i]);
      checkOutput({tag, "_busy"}, {7'd0, busy}, 8'd1);
      step();
    end
    checkOutput({tag, "_done"}, {7'd0, done}, 8'd1);
    checkOutput({tag, "_expect"}, {7'd0, expect_flag}, {7'd0, exp_expect});
    checkOutput({tag, "_idle_valid"}, {7'd0, valid}, 8'd0);
    checkOutput({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
  endtask

  task automatic stallStep(input string tag, input logic [7:0] exp_char, input logic rdy);
    checkOutput({tag, "_valid"}, {7'd0, valid}, 8'd1);
    checkOutput({tag, "_char"}, char, exp_char);
    ready = rdy;
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    ready      = 1'b1;
    alpha_len  = 4'd0;
    digit_len  = 4'd0;
    alpha_base = 5'd0;
    upper      = 1'b0;

    #12;
    checkOutput("rst_char", char, 8'd0);
    checkOutput("rst_valid", {7'd0, valid}, 8'd0);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_expect", {7'd0, expect_flag}, 8'd0);
    rst_n = 1'b1;
    step();
    checkOutput("idle_valid", {7'd0, valid}, 8'd0);

    applyStimulus(4'd2, 4'd3, 5'd0, 1'b0, 1'b0);
    expectSeq("ab012", "ab012 ", 1'b1);
    step();
    checkOutput("ab012_done_pulse", {7'd0, done}, 8'd0);

    applyStimulus(4'd3, 4'd0, 5'd24, 1'b1, 1'b0);
    expectSeq("YZA", "YZA ", 1'b0);
    step();

    applyStimulus(4'd0, 4'd12, 5'd30, 1'b0, 1'b0);
    expectSeq("dwrap", "a012345678901 ", 1'b1);
    step();

    applyStimulus(4'd15, 4'd0, 5'd20, 1'b0, 1'b0);
    expectSeq("len15", "uvwxyzabcdefghi ", 1'b0);
    step();

    // Stall: ready pattern 1,0,0,1 must hold 'g' without skipping or repeating.
    applyStimulus(4'd3, 4'd1, 5'd5, 1'b0, 1'b0);
    stallStep("stall0", "f", 1'b1);
    stallStep("stall1", "g", 1'b0);
    stallStep("stall2", "g", 1'b0);
    stallStep("stall3", "g", 1'b1);
    expectSeq("stall_tail", "h0 ", 1'b1);
    step();

    // Asynchronous reset while in DIGIT.
    applyStimulus(4'd1, 4'd5, 5'd0, 1'b0, 1'b0);
    ready = 1'b1;
    step();
    step();
    checkOutput("pre_rst_char", char, "1");
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_char", char, 8'd0);
    checkOutput("async_valid", {7'd0, valid}, 8'd0);
    checkOutput("async_busy", {7'd0, busy}, 8'd0);
    checkOutput("async_expect", {7'd0, expect_flag}, 8'd0);
    #10 rst_n = 1'b1;
    step();
    checkOutput("post_rst_valid", {7'd0, valid}, 8'd0);
    applyStimulus(4'd2, 4'd1, 5'd1, 1'b0, 1'b0);
    expectSeq("post_rst", "bc0 ", 1'b1);
    step();

    // Start held high: ignored while busy, re-sampled in the done cycle.
    applyStimulus(4'd1, 4'd0, 5'd2, 1'b1, 1'b1);
    expectSeq("held1", "C ", 1'b0);
    step();
    start = 1'b0;
    checkOutput("restart_done", {7'd0, done}, 8'd0);
    expectSeq("held2", "C ", 1'b0);
    step();
    checkOutput("final_valid", {7'd0, valid}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/id_gen.md
ID_GEN -- requirements
Module: id_gen

Interface
REQ-001 SHALL have parameter TERM_CHAR, default 8'd32 (space), meaning the terminator byte emitted after each identifier; it must be a non-letter, non-digit value.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request to generate one identifier; sampled only in IDLE.
REQ-005 SHALL have port alpha_len  input  4  number of letters requested (0 treated as 1).
REQ-006 SHALL have port digit_len  input  4  number of digits requested (0 allowed).
REQ-007 SHALL have port alpha_base  input  5  index of the first letter, 0='a'; values 26..31 treated as 0.
REQ-008 SHALL have port upper  input  1  1 selects 'A'..'Z', 0 selects 'a'..'z'.
REQ-009 SHALL have port char  output  8  ASCII byte being offered.
REQ-010 SHALL have port valid  output  1  char is valid.
REQ-011 SHALL have port ready  input  1  consumer accepts char this cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port expect  output  1  registered flag: 1 when the identifier just completed ended in a digit; valid while done=1.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the terminator is accepted.

Function
REQ-015 SHALL implement states IDLE, ALPHA, DIGIT, TERM.
REQ-016 SHALL, in IDLE with start=1, latch alpha_len, digit_len, alpha_base and upper, and move to ALPHA; other inputs are ignored outside IDLE.
REQ-017 SHALL assert valid with the first letter in the cycle after start is sampled; latency from start to first valid is 1 cycle.
REQ-018 SHALL advance to the next character only on a handshake (valid=1 and ready=1); char and valid SHALL hold stable while valid=1 and ready=0.
REQ-019 SHALL emit letters from alpha_base, incrementing by one per handshake, wrapping 25 to 0 ('z' to 'a', 'Z' to 'A').
REQ-020 SHALL emit digits starting at '0', incrementing per handshake, wrapping '9' to '0'.
REQ-021 SHALL transition ALPHA to DIGIT on the handshake of the last letter when the latched digit_len>0, otherwise ALPHA to TERM.
REQ-022 SHALL transition DIGIT to TERM on the handshake of the last digit.
REQ-023 SHALL, in TERM, offer TERM_CHAR; on its handshake, return to IDLE, pulse done for one cycle, and set expect = (latched digit_len != 0).
REQ-024 SHALL keep valid=0 in IDLE; a start in the same cycle as done is sampled, since the block is already in IDLE when done is high.
REQ-025 SHALL use 4-bit remaining-count counters; a latched count of 15 SHALL produce exactly 15 characters.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-identifier, asynchronously force state=IDLE, char=8'd0, valid=0, busy=0, done=0, expect=0, and clear all counters; the partial identifier is abandoned without a terminator.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-028 SHALL place the state encoding, ASCII constants ('0'=48, 'A'=65, 'a'=97) and letter/digit modulus constants in shared package id_pkg.
REQ-029 SHALL use one sub-module, id_char_sel: a combinational mapping of class, index and upper to an ASCII byte.
REQ-030 SHALL register all outputs.

Verification
REQ-031 Scenario: start with alpha_len=2, digit_len=3, alpha_base=0, upper=0, ready=1 -> "ab012" then 32 on consecutive cycles, done with expect=1; an attached recognizer reports valid identifier after '2'.
REQ-032 Scenario: alpha_len=3, digit_len=0, alpha_base=24, upper=1 -> "YZA" then 32, expect=0.
REQ-033 Scenario: alpha_len=0, digit_len=12, alpha_base=30 -> "a0123456789" followed by "01" then 32 (alpha_len 0 treated as 1, base clamped to 0, digits wrap).
REQ-034 Scenario: ready toggles 1,0,0,1 -> char and valid are stable during the stall; no character is skipped or duplicated.
REQ-035 Scenario: rst_n pulsed low during DIGIT -> outputs zero immediately, without waiting for a clock edge; after release, a new start produces a full correct identifier.
REQ-036 Scenario: start held high while busy -> ignored; a second start sampled in the done cycle begins a new identifier on the next cycle.
